ay8_bus_arbiter: RTL and testbench

Two-master arbiter and sequencer for the AY8 single-port memory bus. Requester 0 is the CPU instruction fetch and requester 1 is the data/load-store port. The block grants the bus round-robin, drives one registered read or write transaction at a time with optional wait states, and returns read data with a one-cycle ack pulse. It replaces direct tri-state driving of the shared bus with an explicit registered mux.

---
 rtl/ay8_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_ay8_bus_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ay8_bus_arbiter.sv
// ay8_bus_arbiter: round-robin two-master arbiter and sequencer for the AY8 bus.
// Ports: CLK/RST, per-master req/we/addr/wdata/gnt/ack, rdata, mem_* strobes, busy.
module ay8_bus_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    DATA
  } state_t;

  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic        sel;
  logic        we_l;
  logic        rr;

  logic              el0;
  logic              el1;
  logic              pick;
  logic              we_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;

  // a master still seeing its ack is just finishing; keep it out
  assign el0 = req0 & ~ack0;
  assign el1 = req1 & ~ack1;

  // rr=1 favours master 1 when both are eligible
  assign pick    = el1 & (~el0 | rr);
  assign we_s    = pick ? we1 : we0;
  assign addr_s  = pick ? addr1 : addr0;
  assign wdata_s = pick ? wdata1 : wdata0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= 1'b0;
      we_l      <= 1'b0;
      rr        <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (el0 | el1) begin
            sel       <= pick;
            we_l      <= we_s;
            mem_addr  <= addr_s;
            mem_wdata <= wdata_s;
            gnt0      <= ~pick;
            gnt1      <= pick;
            mem_rd    <= ~we_s;
            mem_wr    <= we_s;
            busy      <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          mem_wr <= 1'b0;
          cnt    <= WLOAD;
          state  <= (WAIT_CYCLES > 0) ? WAIT : DATA;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= DATA;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DATA: begin
          mem_rd <= 1'b0;
          if (!we_l) begin
            rdata <= mem_rdata;
          end
          ack0  <= ~sel;
          ack1  <= sel;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
          // last-served master drops to lowest priority
          rr    <= ~sel;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ay8_bus_arbiter.sv
// tb_ay8_bus_arbiter: directed bench for ay8_bus_arbiter with WAIT_CYCLES 0 and 2.
// A transaction-timeline model is compared against both instances every cycle.
module tb_ay8_bus_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  logic [1:0]      req0, we0, req1, we1;
  logic [1:0]      gnt0, gnt1, ack0, ack1;
  logic [1:0]      mem_rd, mem_wr, busy;
  logic [1:0][7:0] addr0, wdata0, addr1, wdata1;
  logic [1:0][7:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [7:0] dmem0 [256];
  logic [7:0] dmem1 [256];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ay8_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) u_w0 (
    .CLK(CLK), .RST(RST),
    .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]),
    .gnt0(gnt0[0]), .ack0(ack0[0]),
    .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]),
    .gnt1(gnt1[0]), .ack1(ack1[0]),
    .rdata(rdata[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rd(mem_rd[0]), .mem_wr(mem_wr[0]), .mem_rdata(mem_rdata[0]),
    .busy(busy[0])
  );

  ay8_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) u_w2 (
    .CLK(CLK), .RST(RST),
    .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]),
    .gnt0(gnt0[1]), .ack0(ack0[1]),
    .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]),
    .gnt1(gnt1[1]), .ack1(ack1[1]),
    .rdata(rdata[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rd(mem_rd[1]), .mem_wr(mem_wr[1]), .mem_rdata(mem_rdata[1]),
    .busy(busy[1])
  );

  assign mem_rdata[0] = dmem0[mem_addr[0]];
  assign mem_rdata[1] = dmem1[mem_addr[1]];

  always @(posedge CLK) begin
    if (mem_wr[0]) dmem0[mem_addr[0]] <= mem_wdata[0];
    if (mem_wr[1]) dmem1[mem_addr[1]] <= mem_wdata[1];
  end

  // ---------------- model ----------------
  int         mw [2] = '{0, 2};
  logic [7:0] mm [2][256];
  bit         m_act [2];
  bit         m_own [2];
  bit         m_we [2];
  int         m_age [2];
  bit         m_ack0 [2];
  bit         m_ack1 [2];
  bit         m_rr [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_wd [2];
  logic [7:0] m_rdata [2];

  function automatic logic [7:0] init_val(input int a);
    logic [7:0] v;
    v = 8'(a) ^ 8'h5A;
    if (a == 8'h12) v = 8'hA5;
    if (a == 8'h05) v = 8'h5E;
    return v;
  endfunction

  task automatic mreset_all();
    for (int i = 0; i < 2; i++) begin
      m_act[i]   = 1'b0;
      m_own[i]   = 1'b0;
      m_we[i]    = 1'b0;
      m_age[i]   = 0;
      m_ack0[i]  = 1'b0;
      m_ack1[i]  = 1'b0;
      m_rr[i]    = 1'b0;
      m_addr[i]  = 8'h00;
      m_wd[i]    = 8'h00;
      m_rdata[i] = 8'h00;
    end
  endtask

  // one transaction spans ADDR + WAIT_CYCLES + DATA = mw+2 cycles
  task automatic mstep(input int i);
    bit e0, e1, p;
    if (m_act[i]) begin
      if (m_age[i] == mw[i] + 2) begin
        if (!m_we[i]) m_rdata[i] = mm[i][m_addr[i]];
        m_ack0[i] = !m_own[i];
        m_ack1[i] = m_own[i];
        m_rr[i]   = !m_own[i];
        m_act[i]  = 1'b0;
      end else begin
        m_age[i]++;
      end
    end else begin
      e0 = req0[i] && !m_ack0[i];
      e1 = req1[i] && !m_ack1[i];
      m_ack0[i] = 1'b0;
      m_ack1[i] = 1'b0;
      if (e0 || e1) begin
        if (e0 && e1) p = m_rr[i];
        else          p = e1;
        m_act[i]  = 1'b1;
        m_own[i]  = p;
        m_we[i]   = p ? we1[i] : we0[i];
        m_addr[i] = p ? addr1[i] : addr0[i];
        m_wd[i]   = p ? wdata1[i] : wdata0[i];
        m_age[i]  = 1;
        if (m_we[i]) mm[i][m_addr[i]] = m_wd[i];
      end
    end
  endtask

  initial begin
    mreset_all();
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) mreset_all();
      else for (int i = 0; i < 2; i++) mstep(i);
    end
  end

  task automatic chk(input string name, input int i,
                     input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h",
               name, i, $time, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        chk("gnt0", i, 8'(gnt0[i]), 8'(m_act[i] && !m_own[i]));
        chk("gnt1", i, 8'(gnt1[i]), 8'(m_act[i] && m_own[i]));
        chk("ack0", i, 8'(ack0[i]), 8'(m_ack0[i]));
        chk("ack1", i, 8'(ack1[i]), 8'(m_ack1[i]));
        chk("busy", i, 8'(busy[i]), 8'(m_act[i]));
        chk("mem_rd", i, 8'(mem_rd[i]), 8'(m_act[i] && !m_we[i]));
        chk("mem_wr", i, 8'(mem_wr[i]),
            8'(m_act[i] && m_we[i] && m_age[i] == 1));
        chk("mem_addr", i, mem_addr[i], m_addr[i]);
        chk("mem_wdata", i, mem_wdata[i], m_wd[i]);
        chk("rdata", i, rdata[i], m_rdata[i]);
        chk("gnt_excl", i, 8'(gnt0[i] & gnt1[i]), 8'h00);
        chk("strobe_excl", i, 8'(mem_rd[i] & mem_wr[i]), 8'h00);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  int order [$];

  initial begin
    req0 = '0; we0 = '0; req1 = '0; we1 = '0;
    addr0 = '0; wdata0 = '0; addr1 = '0; wdata1 = '0;
    for (int a = 0; a < 256; a++) begin
      dmem0[a] = init_val(a);
      dmem1[a] = init_val(a);
      mm[0][a] = init_val(a);
      mm[1][a] = init_val(a);
    end

    step(2);
    chk("rst_busy", 0, 8'(busy[0]), 8'h00);
    chk("rst_gnt0", 0, 8'(gnt0[0]), 8'h00);
    chk("rst_rdata", 1, rdata[1], 8'h00);
    RST = 1'b1;

    // single read, master 0, no wait states
    req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 8'h12;
    step(1);
    chk("rd_c1_gnt0", 0, 8'(gnt0[0]), 8'h01);
    chk("rd_c1_mem_rd", 0, 8'(mem_rd[0]), 8'h01);
    chk("rd_c1_addr", 0, mem_addr[0], 8'h12);
    step(1);
    chk("rd_c2_gnt0", 0, 8'(gnt0[0]), 8'h01);
    chk("rd_c2_mem_rd", 0, 8'(mem_rd[0]), 8'h01);
    step(1);
    chk("rd_c3_ack0", 0, 8'(ack0[0]), 8'h01);
    chk("rd_c3_rdata", 0, rdata[0], 8'hA5);
    chk("rd_c3_busy", 0, 8'(busy[0]), 8'h00);
    req0[0] = 1'b0;
    step(1);

    // single write, master 1
    req1[0] = 1'b1; we1[0] = 1'b1; addr1[0] = 8'h40; wdata1[0] = 8'h3C;
    step(1);
    chk("wr_c1_mem_wr", 0, 8'(mem_wr[0]), 8'h01);
    chk("wr_c1_addr", 0, mem_addr[0], 8'h40);
    chk("wr_c1_wdata", 0, mem_wdata[0], 8'h3C);
    chk("wr_c1_gnt1", 0, 8'(gnt1[0]), 8'h01);
    step(1);
    chk("wr_c2_mem_wr", 0, 8'(mem_wr[0]), 8'h00);
    step(1);
    chk("wr_c3_ack1", 0, 8'(ack1[0]), 8'h01);
    chk("wr_c3_rdata", 0, rdata[0], 8'hA5);
    req1[0] = 1'b0; we1[0] = 1'b0;
    step(1);
    chk("wr_mem40", 0, dmem0[8'h40], 8'h3C);

    // ack masking, then dropping req mid-transaction
    req0[0] = 1'b1; addr0[0] = 8'h30;
    step(3);
    chk("mask_c3_ack0", 0, 8'(ack0[0]), 8'h01);
    step(1);
    chk("mask_c4_busy", 0, 8'(busy[0]), 8'h00);
    chk("mask_c4_gnt0", 0, 8'(gnt0[0]), 8'h00);
    step(1);
    chk("mask_c5_gnt0", 0, 8'(gnt0[0]), 8'h01);
    chk("mask_c5_mem_rd", 0, 8'(mem_rd[0]), 8'h01);
    req0[0] = 1'b0;
    step(2);
    chk("mask_c7_ack0", 0, 8'(ack0[0]), 8'h01);
    chk("mask_c7_rdata", 0, rdata[0], 8'h6A);
    step(1);

    // contention from reset: expect 0,1,0,1
    RST = 1'b0;
    req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 8'h20;
    req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 8'h21;
    step(1);
    RST = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (ack0[0] || ack1[0]) order.push_back(ack1[0] ? 1 : 0);
      chk("cont_ack_slot", 0, 8'(ack0[0] | ack1[0]), 8'((k % 3) == 0));
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    chk("cont_count", 0, 8'(order.size()), 8'd4);
    if (order.size() == 4) begin
      chk("cont_o0", 0, 8'(order[0]), 8'd0);
      chk("cont_o1", 0, 8'(order[1]), 8'd1);
      chk("cont_o2", 0, 8'(order[2]), 8'd0);
      chk("cont_o3", 0, 8'(order[3]), 8'd1);
    end
    step(2);

    // two wait states
    req0[1] = 1'b1; we0[1] = 1'b0; addr0[1] = 8'h05;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk("wait_mem_rd", 1, 8'(mem_rd[1]), 8'h01);
      chk("wait_ack0", 1, 8'(ack0[1]), 8'h00);
    end
    step(1);
    chk("wait_c5_ack0", 1, 8'(ack0[1]), 8'h01);
    chk("wait_c5_rdata", 1, rdata[1], 8'h5E);
    chk("wait_c5_mem_rd", 1, 8'(mem_rd[1]), 8'h00);
    req0[1] = 1'b0;
    step(2);

    // reset during WAIT aborts the read
    req0[1] = 1'b1; addr0[1] = 8'h07;
    step(2);
    chk("abort_pre_rd", 1, 8'(mem_rd[1]), 8'h01);
    #2 RST = 1'b0;
    #1;
    chk("abort_mem_rd", 1, 8'(mem_rd[1]), 8'h00);
    chk("abort_gnt0", 1, 8'(gnt0[1]), 8'h00);
    chk("abort_busy", 1, 8'(busy[1]), 8'h00);
    req0[1] = 1'b0;
    step(1);
    chk("abort_no_ack", 1, 8'(ack0[1]), 8'h00);
    RST = 1'b1;
    req1[1] = 1'b1; we1[1] = 1'b0; addr1[1] = 8'h09;
    step(1);
    chk("post_gnt1", 1, 8'(gnt1[1]), 8'h01);
    step(4);
    chk("post_ack1", 1, 8'(ack1[1]), 8'h01);
    chk("post_rdata", 1, rdata[1], 8'h53);
    req1[1] = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
